ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter FILL_ON_RESET, default 1: when 1, the block zero-fills the RAM automatically after reset.
REQ-002 Parameter INIT_VALUE, default 8'h00: byte written to every location during a fill.
REQ-003 Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 init_start  input  1  request a fill of the whole RAM.
REQ-007 busy  output  1  high while a fill is in progress.
REQ-008 init_done  output  1  one-cycle pulse when a fill completes.
REQ-009 a_valid, a_we  input  1 each  requester A: request valid, write (1) or read (0).
REQ-010 a_addr, a_wdata  input  8 each  requester A: address and write data.
REQ-011 a_ready  output  1  requester A: request accepted this cycle.
REQ-012 a_rvalid  output  1  requester A: read data valid.
REQ-013 a_rdata  output  8  requester A: read data.
REQ-014 b_*  same set of ports, widths and meanings as a_*, for requester B.
REQ-015 ram_address, ram_data_in  output  8 each  to the RAM address and data inputs.
REQ-016 ram_write_enable  output  1  RAM write strobe.
REQ-017 ram_data_out  input  8  RAM registered read data, updated on each non-write edge.

Function
REQ-018 FSM states: SERVE, FILL.
- SERVE -> FILL on init_start=1.
- FILL -> SERVE after the write to address 255.
REQ-019 Accept:
- A request is accepted when x_valid && x_ready at a rising edge.
- x_ready is combinational and high only in SERVE with init_start=0 and x granted.
REQ-020 Grant:
- Only one valid requester: it is granted.
- Both valid: the requester not granted at the most recent accept is granted (round-robin).
- last_grant updates only on an accept.
REQ-021 On an accept, the same cycle drives ram_address=x_addr, ram_data_in=x_wdata, ram_write_enable=x_we; at most one requester is accepted per cycle.
REQ-022 No accept and not in FILL: ram_write_enable=0, ram_address=0, ram_data_in=0.
REQ-023 Read latency: a read accepted at edge N gives x_rvalid=1 for exactly the cycle after edge N, with x_rdata=ram_data_out in that cycle.
REQ-024 Read-response rules:
- The response has no backpressure.
- Back-to-back reads give back-to-back rvalid.
- Writes produce no response.
REQ-025 x_rdata SHALL be 8'h00 whenever x_rvalid=0.
REQ-026 Same-address accesses from A and B are serialized in grant order; a read granted after a write returns the new data.
REQ-027 FILL behaviour:
- 8-bit counter from 0 to 255; each cycle drives ram_address=counter, ram_data_in=INIT_VALUE, ram_write_enable=1.
- a_ready=b_ready=0; exactly 256 cycles.
REQ-028 init_done SHALL pulse for one cycle, the cycle after the write to address 255; busy SHALL be high during the 256 FILL cycles only.
REQ-029 init_start in the same cycle as valid requests: fill wins, both ready=0, requests stay pending.
REQ-030 init_start during FILL SHALL be ignored and SHALL NOT restart the counter.
REQ-031 A read accepted in the cycle before FILL entry SHALL still deliver its rvalid in the first FILL cycle.

Reset
REQ-032 On rst_n=0, immediately and asynchronously:
- a_rvalid=b_rvalid=0, init_done=0, counter=0, last_grant=B.
- State is FILL if FILL_ON_RESET=1, else SERVE.
- busy follows the state.
REQ-033 Reset asserted mid-fill or mid-read:
- Any pending response is discarded.
- A fill restarts from address 0 after release when FILL_ON_RESET=1.

Verification
REQ-034 FILL_ON_RESET=1, INIT_VALUE=8'hA5, release reset -> busy=1 for 256 cycles, init_done pulse, then A reads addr 8'h7F -> a_rvalid next cycle with a_rdata=8'hA5.
REQ-035 A writes 8'h3C to 8'h10; next cycle B reads 8'h10 -> b_rvalid one cycle after accept, b_rdata=8'h3C, a_rvalid stays 0.
REQ-036 A and B both hold valid reads for 4 cycles after reset (last_grant=B) -> accepts alternate A, B, A, B; each rvalid pulses exactly once per accept.
REQ-037 init_start asserted together with a_valid=1 -> a_ready=0, 256-cycle fill, then A accepted in the first SERVE cycle; init_start pulsed again at fill cycle 100 -> fill still ends at cycle 256.
REQ-038 Assert rst_n=0 at fill cycle 50 for 2 cycles -> outputs at reset values immediately, fill restarts from address 0, full 256 cycles, single init_done.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between two RAM requesters, the arbiter and the RAM port.
// The slave modport is the arbiter's view; master is the environment's view.
interface ram_arbiter_if;
  logic       init_start;
  logic       busy;
  logic       init_done;

  logic       a_valid;
  logic       a_we;
  logic [7:0] a_addr;
  logic [7:0] a_wdata;
  logic       a_ready;
  logic       a_rvalid;
  logic [7:0] a_rdata;

  logic       b_valid;
  logic       b_we;
  logic [7:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_ready;
  logic       b_rvalid;
  logic [7:0] b_rdata;

  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enable;
  logic [7:0] ram_data_out;

  modport slave (
    input  init_start,
    output busy, init_done,
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    output ram_address, ram_data_in, ram_write_enable,
    input  ram_data_out
  );

  modport master (
    output init_start,
    input  busy, init_done,
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    input  ram_address, ram_data_in, ram_write_enable,
    output ram_data_out
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a
// registered read port, plus a whole-RAM fill engine (after reset and on
// init_start).
//
// state | meaning
// SERVE | arbitrate A/B requests, one RAM access per cycle
// FILL  | write INIT_VALUE to addresses 0..255, requesters held off
module ram_arbiter #(
  parameter bit         FILL_ON_RESET = 1'b1,
  parameter logic [7:0] INIT_VALUE    = 8'h00
) (
  input logic           clk,
  input logic           rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic {
    SERVE = 1'b0,
    FILL  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = FILL_ON_RESET ? FILL : SERVE;

  state_t     state;
  logic [7:0] fill_cnt;
  logic       last_grant_b;
  logic       a_rvalid_q;
  logic       b_rvalid_q;
  logic       init_done_q;

  logic       serving;
  logic       grant_a;
  logic       grant_b;
  logic       accept_a;
  logic       accept_b;

  // Round-robin grant: a lone requester always wins; on a tie the side
  // that lost the last accept wins. Ready is withheld while filling or
  // when a fill is being requested this cycle.
  always_comb begin
    serving  = (state == SERVE) && !bus.init_start;
    grant_a  = bus.a_valid && (!bus.b_valid || last_grant_b);
    grant_b  = bus.b_valid && !grant_a;
    accept_a = serving && grant_a;
    accept_b = serving && grant_b;
  end

  assign bus.a_ready = accept_a;
  assign bus.b_ready = accept_b;

  // RAM port mux: fill engine, then the accepted requester, else idle zeros.
  always_comb begin
    bus.ram_address      = 8'h00;
    bus.ram_data_in      = 8'h00;
    bus.ram_write_enable = 1'b0;
    if (state == FILL) begin
      bus.ram_address      = fill_cnt;
      bus.ram_data_in      = INIT_VALUE;
      bus.ram_write_enable = 1'b1;
    end else if (accept_a) begin
      bus.ram_address      = bus.a_addr;
      bus.ram_data_in      = bus.a_wdata;
      bus.ram_write_enable = bus.a_we;
    end else if (accept_b) begin
      bus.ram_address      = bus.b_addr;
      bus.ram_data_in      = bus.b_wdata;
      bus.ram_write_enable = bus.b_we;
    end
  end

  // The RAM's own output register supplies the data; the arbiter only
  // steers it to the owner of the response and zeros it otherwise.
  assign bus.a_rdata   = a_rvalid_q ? bus.ram_data_out : 8'h00;
  assign bus.b_rdata   = b_rvalid_q ? bus.ram_data_out : 8'h00;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.init_done = init_done_q;
  assign bus.busy      = (state == FILL);

  // Control FSM with fill counter, grant history and response flags.
  // Read responses are registered regardless of state so a read accepted
  // just before a fill still returns in the first fill cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RESET_STATE;
      fill_cnt     <= 8'h00;
      last_grant_b <= 1'b1;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      a_rvalid_q  <= accept_a && !bus.a_we;
      b_rvalid_q  <= accept_b && !bus.b_we;
      init_done_q <= 1'b0;
      case (state)
        SERVE: begin
          if (bus.init_start) begin
            state    <= FILL;
            fill_cnt <= 8'h00;
          end else if (accept_a) begin
            last_grant_b <= 1'b0;
          end else if (accept_b) begin
            last_grant_b <= 1'b1;
          end
        end
        FILL: begin
          if (fill_cnt == 8'hFF) begin
            state       <= SERVE;
            fill_cnt    <= 8'h00;
            init_done_q <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 8'd1;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations,
// then randomized traffic with occasional fills and resets, all checked
// every cycle against a transaction-level model of the arbiter and RAM.
module tb_ram_arbiter;
  localparam logic [7:0] INIT_V = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  ram_arbiter_if bus ();

  ram_arbiter #(.FILL_ON_RESET(1'b1), .INIT_VALUE(INIT_V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM with registered read port: updates its output on non-write edges.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
    else                      bus.ram_data_out <= mem[bus.ram_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_fill_left;   // fill writes still to come, 0 when serving
  bit         m_prefer_a;    // who wins if both ask
  bit         m_a_rv, m_b_rv, m_done;
  logic [7:0] m_a_rd, m_b_rd;
  logic [7:0] shadow [256];

  task automatic model_reset();
    m_fill_left = 256;
    m_prefer_a  = 1'b1;
    m_a_rv = 0; m_b_rv = 0; m_done = 0;
    m_a_rd = 8'h00; m_b_rd = 8'h00;
  endtask

  initial begin : model_proc
    bit         serve, a_win, a_rdy, b_rdy, e_we;
    logic [7:0] e_addr, e_din;
    logic [38:0] exp_v, act_v;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      serve = (m_fill_left == 0) && !bus.init_start;
      a_win = bus.a_valid && (!bus.b_valid || m_prefer_a);
      a_rdy = serve && a_win;
      b_rdy = serve && bus.b_valid && !a_win;
      if (m_fill_left > 0) begin
        e_addr = 8'(256 - m_fill_left); e_din = INIT_V; e_we = 1'b1;
      end else if (a_rdy) begin
        e_addr = bus.a_addr; e_din = bus.a_wdata; e_we = bus.a_we;
      end else if (b_rdy) begin
        e_addr = bus.b_addr; e_din = bus.b_wdata; e_we = bus.b_we;
      end else begin
        e_addr = 8'h00; e_din = 8'h00; e_we = 1'b0;
      end
      exp_v = {m_fill_left > 0, m_done, a_rdy, b_rdy, e_we, e_addr, e_din,
               m_a_rv, m_a_rv ? m_a_rd : 8'h00, m_b_rv, m_b_rv ? m_b_rd : 8'h00};
      act_v = {bus.busy, bus.init_done, bus.a_ready, bus.b_ready, bus.ram_write_enable,
               bus.ram_address, bus.ram_data_in, bus.a_rvalid, bus.a_rdata,
               bus.b_rvalid, bus.b_rdata};
      check("cycle_model", 64'(act_v), 64'(exp_v));
      if (e_we) shadow[e_addr] = e_din;
      if (rst_n) begin
        m_a_rv = a_rdy && !bus.a_we;
        m_a_rd = shadow[bus.a_addr];
        m_b_rv = b_rdy && !bus.b_we;
        m_b_rd = shadow[bus.b_addr];
        m_done = (m_fill_left == 1);
        if (m_fill_left > 0) m_fill_left--;
        else if (bus.init_start) m_fill_left = 256;
        if (a_rdy) m_prefer_a = 1'b0;
        if (b_rdy) m_prefer_a = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Counts busy cycles of a fill; optionally pulses init_start after
  // pulse_at cycles, or returns early (just after a rising edge) at stop_at.
  task automatic fill_measure(input int pulse_at, input int stop_at,
                              output int cycles, output int dones);
    cycles = 0; dones = 0;
    for (int g = 0; g < 700; g++) begin
      @(negedge clk);
      if (bus.init_done) dones++;
      if (!bus.busy) return;
      cycles++;
      @(posedge clk); #1;
      bus.init_start = (cycles == pulse_at);
      if (cycles == stop_at) return;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.init_start = 0;
    bus.a_valid = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_valid = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
  endtask

  initial begin : stim
    int cyc, dn, arv, brv;
    logic [7:0] order;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.ram_data_out = 8'h00;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(bus.busy), 64'd1);
    check("reset_init_done", 64'(bus.init_done), 64'd0);
    check("reset_rvalid", 64'({bus.a_rvalid, bus.b_rvalid}), 64'd0);
    step(); step();
    rst_n = 1'b1;

    // Fill after reset, then read back one location.
    fill_measure(-1, -1, cyc, dn);
    check("reset_fill_len", 64'(cyc), 64'd256);
    check("reset_fill_done", 64'(dn), 64'd1);
    step();
    bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 8'h7F;
    @(negedge clk);
    check("a_ready_7f", 64'(bus.a_ready), 64'd1);
    step();
    bus.a_valid = 0;
    @(negedge clk);
    check("a_read_7f", 64'({bus.a_rvalid, bus.a_rdata}), 64'h1A5);

    // A writes, B reads the same address next cycle.
    step();
    bus.a_valid = 1; bus.a_we = 1; bus.a_addr = 8'h10; bus.a_wdata = 8'h3C;
    step();
    bus.a_valid = 0; bus.a_we = 0;
    bus.b_valid = 1; bus.b_we = 0; bus.b_addr = 8'h10;
    @(negedge clk);
    check("a_write_no_resp", 64'(bus.a_rvalid), 64'd0);
    step();
    bus.b_valid = 0;
    @(negedge clk);
    check("b_read_after_write", 64'({bus.b_rvalid, bus.b_rdata}), 64'h13C);
    check("a_rvalid_quiet", 64'(bus.a_rvalid), 64'd0);

    // init_start with a pending request: fill wins, then A is served.
    step();
    bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 8'h10; bus.init_start = 1;
    @(negedge clk);
    check("fill_beats_request", 64'(bus.a_ready), 64'd0);
    step();
    bus.init_start = 0;
    fill_measure(100, -1, cyc, dn);
    check("fill_len_restart_ignored", 64'(cyc), 64'd256);
    check("fill_done_once", 64'(dn), 64'd1);
    check("a_served_after_fill", 64'(bus.a_ready), 64'd1);
    step();
    bus.a_valid = 0;
    @(negedge clk);
    check("a_read_after_fill", 64'({bus.a_rvalid, bus.a_rdata}), 64'h1A5);

    // Reset at fill cycle 50: restart from 0, single init_done.
    step();
    bus.init_start = 1;
    step();
    bus.init_start = 0;
    fill_measure(-1, 50, cyc, dn);
    rst_n = 1'b0;
    #1;
    check("midfill_reset_state",
          64'({bus.busy, bus.init_done, bus.a_rvalid, bus.b_rvalid, bus.ram_address}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    step(); step();
    rst_n = 1'b1;
    fill_measure(-1, -1, cyc, dn);
    check("refill_len", 64'(cyc), 64'd256);
    check("refill_done", 64'(dn), 64'd1);
    @(negedge clk);
    check("done_single_pulse", 64'(bus.init_done), 64'd0);

    // Both requesters read for 4 cycles: A first (last grant was B).
    step();
    bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 8'h01;
    bus.b_valid = 1; bus.b_we = 0; bus.b_addr = 8'h02;
    order = 8'h00; arv = 0; brv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      order = {order[5:0], bus.a_ready ? 2'd0 : (bus.b_ready ? 2'd1 : 2'd2)};
      arv += int'(bus.a_rvalid); brv += int'(bus.b_rvalid);
      step();
    end
    idle_inputs();
    @(negedge clk);
    arv += int'(bus.a_rvalid); brv += int'(bus.b_rvalid);
    check("rr_order", 64'(order), 64'h11);
    check("rr_rvalid_counts", 64'({arv[7:0], brv[7:0]}), 64'h0202);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.a_we    = 1'($urandom_range(0, 1));
      bus.a_addr  = 8'($urandom_range(0, 7));
      bus.a_wdata = 8'($urandom);
      bus.b_valid = 1'($urandom_range(0, 1));
      bus.b_we    = 1'($urandom_range(0, 1));
      bus.b_addr  = 8'($urandom_range(0, 7));
      bus.b_wdata = 8'($urandom);
      bus.init_start = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    step();
    idle_inputs();
    rst_n = 1'b1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
